// File: rtl/sync_frame_tx_1011.sv
// Serial framer: 1011 sync header, MSB-first payload with zero-stuffing after any 101, then GAP_BITS idle zeros.
// First sync bit is on x the cycle after acceptance; ready is low for the whole frame, so the sender is held off.
module sync_frame_tx_1011 #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              x,
  output logic              busy,
  output logic              done
);

  localparam int         CNT_W    = $clog2(DATA_W + 1);
  localparam logic [3:0] SYNC_HDR = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_GAP
  } state_t;

  // State names the kind of bit currently on x.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [2:0]        hist_q, hist_d;
  logic              x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drive_payload;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    sync_cnt_d    = sync_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    x_d           = 1'b0;
    done_d        = 1'b0;
    drive_payload = 1'b0;
    ready         = (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d    = S_SYNC;
          shreg_d    = data_in;
          bit_cnt_d  = CNT_W'(DATA_W);
          sync_cnt_d = 2'd0;
          x_d        = SYNC_HDR[3];
        end
      end
      S_SYNC: begin
        if (sync_cnt_q == 2'd3) begin
          state_d       = S_DATA;
          drive_payload = 1'b1;
        end else begin
          sync_cnt_d = sync_cnt_q + 2'd1;
          x_d        = SYNC_HDR[2'd2 - sync_cnt_q];
        end
      end
      S_DATA: begin
        // Count test comes first so the frame never ends on a stuff bit.
        if (bit_cnt_q == '0) begin
          state_d   = S_GAP;
          gap_cnt_d = 4'(GAP_BITS - 1);
        end else if (hist_q == 3'b101) begin
          state_d = S_STUFF;
        end else begin
          drive_payload = 1'b1;
        end
      end
      S_STUFF: begin
        state_d       = S_DATA;
        drive_payload = 1'b1;
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (drive_payload) begin
      x_d       = shreg_q[DATA_W-1];
      shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q - CNT_W'(1);
      done_d    = (bit_cnt_q == CNT_W'(1));
    end

    busy_d = (state_d != S_IDLE);
    hist_d = {hist_q[1:0], x_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      sync_cnt_q <= 2'd0;
      gap_cnt_q  <= 4'd0;
      hist_q     <= 3'b000;
      x_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hist_q     <= hist_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x    = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sync_frame_tx_1011.sv
// Directed bench for sync_frame_tx_1011: frame table plus reset, back-to-back and mid-frame reset sequences.
module tb_sync_frame_tx_1011;

  localparam int DATA_W   = 8;
  localparam int GAP_BITS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready, x, busy, done;

  always #5 clk = ~clk;

  sync_frame_tx_1011 #(.DATA_W(DATA_W), .GAP_BITS(GAP_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready    (ready),
    .x        (x),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] bits;  // expected frame bits (header..last payload), right-aligned
    int          len;
  } vec_t;

  vec_t vecs[5];
  logic xs[64];
  logic dn[64];
  logic bs[64];
  logic rs[64];
  int   n;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while (!ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", {31'd0, ready}, 32'd1);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic capture();
    n = 0;
    while (busy && n < 64) begin
      xs[n] = x;
      dn[n] = done;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] bits, input int len);
    logic [15:0] got = '0;
    logic        gap_or = 1'b0;
    int          dcnt = 0, didx = -1, wcnt = 0;
    for (int i = 0; i < len && i < n; i++) got = {got[14:0], xs[i]};
    for (int i = len; i < n; i++) gap_or |= xs[i];
    for (int i = 0; i < n; i++) if (dn[i]) begin dcnt++; didx = i; end
    for (int i = 0; i + 3 < n; i++)
      if ({xs[i], xs[i+1], xs[i+2], xs[i+3]} == 4'b1011) wcnt++;
    check({tag, "_busy_len"}, n, len + GAP_BITS);
    check({tag, "_bits"}, {16'd0, got}, {16'd0, bits});
    check({tag, "_gap_zero"}, {31'd0, gap_or}, 32'd0);
    check({tag, "_done_cnt"}, dcnt, 1);
    check({tag, "_done_idx"}, didx, len - 1);
    check({tag, "_sync_windows"}, wcnt, 1);
  endtask

  initial begin
    logic [15:0] f1, f2;
    int lo_cnt, lo_idx, rdy_cnt, dcnt;

    vecs[0] = '{8'hFF, 16'b101111111111,   12};
    vecs[1] = '{8'hA5, 16'b1011101000101,  13};
    vecs[2] = '{8'hB6, 16'b10111010100110, 14};
    vecs[3] = '{8'h00, 16'b101100000000,   12};
    vecs[4] = '{8'h5A, 16'b10110100110100, 14};

    // Reset with valid held high: nothing may start.
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    check("rst_x",     {31'd0, x},     32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    rst      = 1'b0;
    valid_in = 1'b0;

    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].data);
      capture();
      check_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].len);
    end

    // Back-to-back with valid held; data changes mid-frame must be ignored.
    @(negedge clk);
    begin
      int w = 0;
      while (!ready && w < 60) begin @(negedge clk); w++; end
    end
    data_in  = 8'h00;
    valid_in = 1'b1;
    @(negedge clk);
    data_in = 8'hFF;
    for (int i = 0; i < 27; i++) begin
      xs[i] = x; dn[i] = done; bs[i] = busy; rs[i] = ready;
      @(negedge clk);
    end
    valid_in = 1'b0;
    f1 = '0; f2 = '0; lo_cnt = 0; lo_idx = -1; rdy_cnt = 0;
    for (int i = 0; i < 12; i++) f1 = {f1[14:0], xs[i]};
    for (int i = 15; i < 27; i++) f2 = {f2[14:0], xs[i]};
    for (int i = 0; i < 27; i++) begin
      if (!bs[i]) begin lo_cnt++; lo_idx = i; end
      if (rs[i]) rdy_cnt++;
    end
    check("b2b_frame1",    {16'd0, f1}, {16'd0, 16'b101100000000});
    check("b2b_done1",     {31'd0, dn[11]}, 32'd1);
    check("b2b_sep_zeros", {29'd0, xs[12], xs[13], xs[14]}, 32'd0);
    check("b2b_idle_cnt",  lo_cnt, 1);
    check("b2b_idle_idx",  lo_idx, 12 + GAP_BITS);
    check("b2b_ready_cnt", rdy_cnt, 1);
    check("b2b_frame2",    {16'd0, f2}, {16'd0, 16'b101111111111});

    // Reset on the 6th payload bit of A5 (x index 10: 1011 101 s 0 0 [1]).
    accept(8'hA5);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_x",     {31'd0, x},     32'd0);
    check("mid_rst_busy",  {31'd0, busy},  32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", dcnt, 0);
    accept(8'hFF);
    capture();
    check_frame("after_rst", 16'b101111111111, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
